// File: rtl/dll_ctrl_pkg.sv
// dll_ctrl_pkg: shared state/direction types and the phase-detector decision for the DLL lock sequencer.
package dll_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, INIT, WAIT, SAMPLE, LWAIT, LSAMPLE, FAULT} state_t;
  typedef enum logic [1:0] {NONE, UP, DN} dir_t;
  function automatic dir_t decide(input logic up, input logic dn);
    return (up && !dn) ? UP : (dn && !up) ? DN : NONE;
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: reloadable down-counter that flags the last settle cycle.
module settle_timer #(
  parameter int SETTLE = 4,
  localparam int W = $clog2(SETTLE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? W'(SETTLE - 1) : (cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = cnt == '0;
endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: lock-acquisition sequencer stepping the delay code from PD decisions with harmonic/range recovery.
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int CODE_W     = 6,
  parameter int INIT_CODE  = 0,
  parameter int SETTLE     = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 3,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              en,
  input  logic              pd_up,
  input  logic              pd_dn,
  input  logic              Reset_PD,
  output logic [CODE_W-1:0] code,
  output logic              pd_rst,
  output logic              locked,
  output logic              fault
);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);
  localparam int TW = $clog2(MAX_RETRY + 1);
  localparam logic [CODE_W-1:0] CINIT = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0] CMAX = '1;
  localparam logic [LW-1:0] LMAX = LW'(LOCK_CNT);
  localparam logic [RW-1:0] RMAX = RW'(UNLOCK_RUN);
  localparam logic [TW-1:0] TMAX = TW'(MAX_RETRY);
  state_t state;
  dir_t last_dir, dir;
  logic [LW-1:0] lock_cnt, lcnt_n;
  logic [RW-1:0] run, run_n;
  logic [TW-1:0] retry;
  logic [CODE_W-1:0] code_n;
  logic done, tmr_load, smp, hld, range_err, same, unlock, give_up;
  settle_timer #(.SETTLE(SETTLE)) u_tmr (
    .clk(clk_ext), .rst(rst), .load(tmr_load), .done(done)
  );
  always_comb begin
    dir       = decide(pd_up, pd_dn);
    smp       = state inside {SAMPLE, LSAMPLE};
    hld       = Reset_PD && (state inside {WAIT, SAMPLE, LWAIT, LSAMPLE});
    range_err = smp && ((dir == UP && code == CMAX) || (dir == DN && code == '0));
    tmr_load  = !(state inside {INIT, WAIT, LWAIT}) || done || hld;
    same      = dir != NONE && dir == last_dir;
    run_n     = dir == NONE ? '0 : !same ? RW'(1) : (run == RMAX) ? run : run + 1'b1;
    lcnt_n    = same ? ((run_n > RW'(1)) ? '0 : lock_cnt) : (lock_cnt == LMAX) ? lock_cnt : lock_cnt + 1'b1;
    code_n    = dir == UP ? code + 1'b1 : dir == DN ? code - 1'b1 : code;
    unlock    = run_n >= RMAX;
    give_up   = retry == TMAX;
  end
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code     <= CINIT;
      pd_rst   <= 1'b1;
      locked   <= 1'b0;
      fault    <= 1'b0;
      retry    <= '0;
      lock_cnt <= '0;
      run      <= '0;
      last_dir <= NONE;
    end else if (!en) begin
      state    <= IDLE;
      code     <= CINIT;
      pd_rst   <= 1'b1;
      locked   <= 1'b0;
      fault    <= 1'b0;
      retry    <= '0;
      lock_cnt <= '0;
      run      <= '0;
      last_dir <= NONE;
    end else if (hld || range_err) begin
      state  <= give_up ? FAULT : INIT;
      fault  <= give_up;
      retry  <= give_up ? retry : retry + 1'b1;
      code   <= CINIT;
      pd_rst <= 1'b1;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= INIT;
        INIT: begin
          lock_cnt <= '0;
          run      <= '0;
          last_dir <= NONE;
          state    <= done ? WAIT : INIT;
          pd_rst   <= !done;
        end
        WAIT:  state <= done ? SAMPLE : WAIT;
        LWAIT: state <= done ? LSAMPLE : LWAIT;
        SAMPLE: begin
          code     <= code_n;
          run      <= run_n;
          lock_cnt <= lcnt_n;
          last_dir <= dir == NONE ? last_dir : dir;
          state    <= lcnt_n == LMAX ? LWAIT : WAIT;
          locked   <= lcnt_n == LMAX;
        end
        LSAMPLE: begin
          code     <= code_n;
          run      <= run_n;
          lock_cnt <= unlock ? '0 : lcnt_n;
          last_dir <= dir == NONE ? last_dir : dir;
          state    <= unlock ? WAIT : LWAIT;
          locked   <= !unlock;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: directed table and sequence checks for the DLL lock sequencer.
module tb_dll_lock_ctrl;
  logic clk_ext = 1'b0, rst = 1'b1, en = 1'b0, pd_up = 1'b0, pd_dn = 1'b0, Reset_PD = 1'b0;
  logic [5:0] code;
  logic pd_rst, locked, fault;
  int total = 0, passed = 0;
  typedef struct {
    logic up;
    logic dn;
    logic [5:0] code;
    logic locked;
  } vec_t;
  vec_t tbl [16];
  always #5 clk_ext = ~clk_ext;
  dll_lock_ctrl dut (
    .clk_ext(clk_ext), .rst(rst), .en(en), .pd_up(pd_up), .pd_dn(pd_dn),
    .Reset_PD(Reset_PD), .code(code), .pd_rst(pd_rst), .locked(locked), .fault(fault)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_ext);
      #1;
    end
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 6'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 6'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 6'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 6'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 6'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 6'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 6'd1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 6'd1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 6'd2, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 6'd2, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 6'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 6'd2, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 6'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 6'd0, 1'b0};
    step(2);
    chk("rst_code", code, 0);
    chk("rst_pd_rst", pd_rst, 1);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    step();
    chk("idle_pd_rst", pd_rst, 1);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("init_pd_rst_%0d", i), pd_rst, 1);
    end
    step();
    chk("pd_rst_fall", pd_rst, 0);
    chk("start_code", code, 0);
    for (int i = 0; i < 16; i++) begin
      pd_up = tbl[i].up;
      pd_dn = tbl[i].dn;
      step(5);
      chk($sformatf("tbl_code_%0d", i), code, int'(tbl[i].code));
      chk($sformatf("tbl_locked_%0d", i), locked, int'(tbl[i].locked));
    end
    pd_up = 1'b1;
    pd_dn = 1'b0;
    for (int i = 1; i < 64; i++) begin
      step(5);
      chk($sformatf("ramp_code_%0d", i), code, i);
    end
    step(5);
    pd_up = 1'b0;
    chk("range_code", code, 0);
    chk("range_pd_rst", pd_rst, 1);
    chk("range_locked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("range_init_%0d", i), pd_rst, 1);
    end
    step();
    chk("range_wait", pd_rst, 0);
    pd_up = 1'b1;
    step(4);
    Reset_PD = 1'b1;
    step();
    Reset_PD = 1'b0;
    pd_up = 1'b0;
    chk("hld_no_inc", code, 0);
    chk("hld_pd_rst", pd_rst, 1);
    chk("hld_locked", locked, 0);
    en = 1'b0;
    step();
    chk("dis_fault", fault, 0);
    chk("dis_pd_rst", pd_rst, 1);
    en = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step(4);
      chk($sformatf("hld_wait_%0d", k), pd_rst, 0);
      Reset_PD = 1'b1;
      step();
      Reset_PD = 1'b0;
      chk($sformatf("hld_pd_rst_%0d", k), pd_rst, 1);
      chk($sformatf("hld_fault_%0d", k), fault, k == 4 ? 1 : 0);
    end
    Reset_PD = 1'b1;
    step(6);
    Reset_PD = 1'b0;
    chk("fault_sticky", fault, 1);
    chk("fault_pd_rst", pd_rst, 1);
    en = 1'b0;
    step();
    chk("fault_clear", fault, 0);
    en = 1'b1;
    step();
    chk("restart_init", pd_rst, 1);
    step(4);
    chk("restart_wait", pd_rst, 0);
    pd_up = 1'b1;
    step(5);
    pd_up = 1'b0;
    chk("pre_rst_code", code, 1);
    step();
    #3 rst = 1'b1;
    #1;
    chk("async_code", code, 0);
    chk("async_pd_rst", pd_rst, 1);
    chk("async_locked", locked, 0);
    step();
    rst = 1'b0;
    chk("held_rst_pd_rst", pd_rst, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
